// File: rtl/sdram_pkg.sv
// Shared types and widths for the SDRAM client arbiter and its helpers.
package sdram_pkg;

  localparam int unsigned ADDR_W = 25;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, REF} arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first asserted request at or after ptr_i,
// searching modulo NREQ.
module rr_pick #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] gnt_o,
  output logic             any_o
);

  always_comb begin
    int unsigned idx;
    idx   = 0;
    gnt_o = ptr_i;
    any_o = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr_i) + k) % NREQ;
      if (!any_o && req_i[IDX_W'(idx)]) begin
        gnt_o = IDX_W'(idx);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller between NREQ level-handshake
// clients, with periodic refresh insertion.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int unsigned NREQ             = 3,
  parameter int unsigned REFRESH_INTERVAL = 512,
  parameter int unsigned REF_HOLD         = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          cl_req,
  input  logic [NREQ-1:0]          cl_we,
  input  logic [NREQ-1:0]          cl_word,
  input  logic [NREQ*ADDR_W-1:0]   cl_addr,
  input  logic [NREQ*DATA_W-1:0]   cl_din,
  output logic [NREQ-1:0]          cl_ack,
  output logic [DATA_W-1:0]        cl_dout,
  output logic [ADDR_W-1:0]        sd_addr,
  output logic                     sd_rd,
  output logic                     sd_wr,
  output logic                     sd_word,
  output logic [DATA_W-1:0]        sd_din,
  input  logic [DATA_W-1:0]        sd_dout,
  input  logic                     sd_busy,
  output logic                     sd_refresh
);

  localparam int unsigned IDX_W  = (NREQ > 2) ? 2 : 1;
  localparam int unsigned CNT_W  = $clog2(REFRESH_INTERVAL);
  localparam int unsigned HOLD_W = $clog2(REF_HOLD + 1);

  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    gnt_q, gnt_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    ref_cnt_q, ref_cnt_d;
  logic                ref_pending_q, ref_pending_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [NREQ-1:0]     cl_ack_q, cl_ack_d;
  logic [DATA_W-1:0]   cl_dout_q, cl_dout_d;
  logic [ADDR_W-1:0]   sd_addr_q, sd_addr_d;
  logic                sd_rd_q, sd_rd_d;
  logic                sd_wr_q, sd_wr_d;
  logic                sd_word_q, sd_word_d;
  logic [DATA_W-1:0]   sd_din_q, sd_din_d;
  logic                sd_refresh_q, sd_refresh_d;
  logic                ref_expire;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i (cl_req),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    rr_ptr_d      = rr_ptr_q;
    hold_d        = hold_q;
    cl_ack_d      = '0;
    cl_dout_d     = cl_dout_q;
    sd_addr_d     = sd_addr_q;
    sd_rd_d       = sd_rd_q;
    sd_wr_d       = sd_wr_q;
    sd_word_d     = sd_word_q;
    sd_din_d      = sd_din_q;
    sd_refresh_d  = 1'b0;

    // An expiry while a refresh is already pending simply merges into it.
    ref_expire    = (ref_cnt_q == CNT_W'(REFRESH_INTERVAL - 1));
    ref_cnt_d     = ref_expire ? '0 : ref_cnt_q + CNT_W'(1);
    ref_pending_d = ref_pending_q | ref_expire;

    unique case (state_q)
      IDLE: begin
        if (ref_pending_q) begin
          ref_pending_d = 1'b0;
          sd_refresh_d  = 1'b1;
          hold_d        = HOLD_W'(REF_HOLD);
          state_d       = REF;
        end else if (pick_any && !sd_busy) begin
          gnt_d     = pick_idx;
          sd_addr_d = cl_addr[ADDR_W*pick_idx +: ADDR_W];
          sd_din_d  = cl_din[DATA_W*pick_idx +: DATA_W];
          sd_word_d = cl_word[pick_idx];
          sd_wr_d   = cl_we[pick_idx];
          sd_rd_d   = !cl_we[pick_idx];
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        // Keep the strobe level up until the controller has taken the edge.
        if (sd_busy) begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!sd_busy) begin
          cl_dout_d        = sd_dout;
          cl_ack_d[gnt_q]  = 1'b1;
          rr_ptr_d         = (gnt_q == IDX_W'(NREQ - 1)) ? '0 : gnt_q + IDX_W'(1);
          state_d          = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      REF: begin
        if (hold_q == '0) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      rr_ptr_q      <= '0;
      ref_cnt_q     <= '0;
      ref_pending_q <= 1'b0;
      hold_q        <= '0;
      cl_ack_q      <= '0;
      cl_dout_q     <= '0;
      sd_addr_q     <= '0;
      sd_rd_q       <= 1'b0;
      sd_wr_q       <= 1'b0;
      sd_word_q     <= 1'b0;
      sd_din_q      <= '0;
      sd_refresh_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      rr_ptr_q      <= rr_ptr_d;
      ref_cnt_q     <= ref_cnt_d;
      ref_pending_q <= ref_pending_d;
      hold_q        <= hold_d;
      cl_ack_q      <= cl_ack_d;
      cl_dout_q     <= cl_dout_d;
      sd_addr_q     <= sd_addr_d;
      sd_rd_q       <= sd_rd_d;
      sd_wr_q       <= sd_wr_d;
      sd_word_q     <= sd_word_d;
      sd_din_q      <= sd_din_d;
      sd_refresh_q  <= sd_refresh_d;
    end
  end

  assign cl_ack     = cl_ack_q;
  assign cl_dout    = cl_dout_q;
  assign sd_addr    = sd_addr_q;
  assign sd_rd      = sd_rd_q;
  assign sd_wr      = sd_wr_q;
  assign sd_word    = sd_word_q;
  assign sd_din     = sd_din_q;
  assign sd_refresh = sd_refresh_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter against a simple 5-cycle SDRAM controller model.
module tb_sdram_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  cl_req;
  logic [2:0]  cl_we;
  logic [2:0]  cl_word;
  logic [74:0] cl_addr;
  logic [47:0] cl_din;
  logic [2:0]  cl_ack;
  logic [15:0] cl_dout;
  logic [24:0] sd_addr;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_word;
  logic [15:0] sd_din;
  logic [15:0] sd_dout;
  logic        sd_busy;
  logic        sd_refresh;

  // Controller model: takes rd/wr level or refresh when idle, then busy 5 cycles.
  logic [2:0]  busy_cnt = '0;
  logic        hold_off;
  logic [15:0] rd_data;
  logic        m_is_wr;
  logic [15:0] m_din;
  int          n_overlap = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  sdram_arbiter #(
    .NREQ             (3),
    .REFRESH_INTERVAL (16),
    .REF_HOLD         (6)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cl_req     (cl_req),
    .cl_we      (cl_we),
    .cl_word    (cl_word),
    .cl_addr    (cl_addr),
    .cl_din     (cl_din),
    .cl_ack     (cl_ack),
    .cl_dout    (cl_dout),
    .sd_addr    (sd_addr),
    .sd_rd      (sd_rd),
    .sd_wr      (sd_wr),
    .sd_word    (sd_word),
    .sd_din     (sd_din),
    .sd_dout    (sd_dout),
    .sd_busy    (sd_busy),
    .sd_refresh (sd_refresh)
  );

  assign sd_busy = (busy_cnt != 3'd0);
  assign sd_dout = rd_data;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (busy_cnt != 3'd0) begin
      busy_cnt <= busy_cnt - 3'd1;
    end else if (!hold_off && sd_refresh) begin
      busy_cnt <= 3'd5;
    end else if (!hold_off && (sd_rd || sd_wr)) begin
      busy_cnt <= 3'd5;
      m_is_wr  <= sd_wr;
      m_din    <= sd_din;
    end
  end

  always @(posedge clk) begin
    if ((sd_rd || sd_wr) && sd_refresh) n_overlap <= n_overlap + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset    = 1'b1;
    cl_req   = '0;
    hold_off = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic set_client(input int i, input logic we, input logic word,
                            input logic [24:0] addr, input logic [15:0] din);
    cl_we[i]             = we;
    cl_word[i]           = word;
    cl_addr[25*i +: 25]  = addr;
    cl_din[16*i +: 16]   = din;
  endtask

  task automatic wait_ack(output int n, output logic [2:0] a);
    n = 0;
    while (cl_ack == 3'b000 && n < 200) begin
      tick();
      n++;
    end
    a = cl_ack;
  endtask

  task automatic test_reset();
    reset_dut();
    n_chk++;
    if ({sd_rd, sd_wr, sd_refresh, sd_word, cl_ack} !== 7'b0)
      $display("FAIL reset_strobes: got %b want 0", {sd_rd, sd_wr, sd_refresh, sd_word, cl_ack});
    else n_pass++;
    n_chk++;
    if ({cl_dout, sd_addr, sd_din} !== 57'b0)
      $display("FAIL reset_data: got %h want 0", {cl_dout, sd_addr, sd_din});
    else n_pass++;
  endtask

  task automatic test_single_read();
    int n;
    logic [2:0] a;
    reset_dut();
    rd_data = 16'hBEEF;
    set_client(1, 1'b0, 1'b1, 25'h000124, 16'h0);
    cl_req = 3'b010;
    n_chk++;
    if (sd_rd !== 1'b0) $display("FAIL rd_before_grant: got %b want 0", sd_rd);
    else n_pass++;
    tick();
    n_chk++;
    if ({sd_rd, sd_wr, sd_word} !== 3'b101) $display("FAIL rd_rise: got %b want 101", {sd_rd, sd_wr, sd_word});
    else n_pass++;
    n_chk++;
    if (sd_addr !== 25'h000124) $display("FAIL rd_addr: got %h want 000124", sd_addr);
    else n_pass++;
    tick();
    n_chk++;
    if ({sd_busy, sd_rd} !== 2'b11) $display("FAIL rd_held_at_busy: got %b want 11", {sd_busy, sd_rd});
    else n_pass++;
    tick();
    n_chk++;
    if (sd_rd !== 1'b0) $display("FAIL rd_drop: got %b want 0", sd_rd);
    else n_pass++;
    wait_ack(n, a);
    n_chk++;
    if (n + 3 !== 8) $display("FAIL rd_latency: got %0d want 8", n + 3);
    else n_pass++;
    n_chk++;
    if (a !== 3'b010) $display("FAIL rd_ack: got %b want 010", a);
    else n_pass++;
    n_chk++;
    if (cl_dout !== 16'hBEEF) $display("FAIL rd_dout: got %h want beef", cl_dout);
    else n_pass++;
    cl_req = '0;
    tick();
    n_chk++;
    if (cl_ack !== 3'b000) $display("FAIL rd_ack_width: got %b want 000", cl_ack);
    else n_pass++;
  endtask

  task automatic test_byte_write();
    int n;
    logic [2:0] a;
    reset_dut();
    set_client(2, 1'b1, 1'b0, 25'h000011, 16'h00AB);
    cl_req = 3'b100;
    tick();
    n_chk++;
    if ({sd_wr, sd_rd, sd_word} !== 3'b100) $display("FAIL wr_strobes: got %b want 100", {sd_wr, sd_rd, sd_word});
    else n_pass++;
    n_chk++;
    if ({sd_addr, sd_din} !== {25'h000011, 16'h00AB})
      $display("FAIL wr_fields: got %h/%h want 000011/00ab", sd_addr, sd_din);
    else n_pass++;
    wait_ack(n, a);
    n_chk++;
    if (a !== 3'b100) $display("FAIL wr_ack: got %b want 100", a);
    else n_pass++;
    n_chk++;
    if ({m_is_wr, m_din} !== {1'b1, 16'h00AB}) $display("FAIL wr_seen: got %b/%h want 1/00ab", m_is_wr, m_din);
    else n_pass++;
    cl_req = '0;
    tick();
  endtask

  task automatic test_round_robin();
    int n;
    int bad_width;
    logic [2:0] a;
    logic [2:0] exp;
    reset_dut();
    bad_width = 0;
    for (int i = 0; i < 3; i++) set_client(i, 1'b0, 1'b1, 25'h100 + 25'(i), 16'h0);
    cl_req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      wait_ack(n, a);
      exp = 3'b001 << (k % 3);
      n_chk++;
      if (a !== exp) $display("FAIL rr_order_%0d: got %b want %b", k, a, exp);
      else n_pass++;
      tick();
      if (cl_ack !== 3'b000) bad_width++;
    end
    n_chk++;
    if (bad_width !== 0) $display("FAIL rr_ack_width: got %0d long acks want 0", bad_width);
    else n_pass++;
    cl_req = '0;
    repeat (10) tick();
  endtask

  task automatic test_refresh_priority();
    int n;
    logic [2:0] a;
    reset_dut();
    set_client(0, 1'b0, 1'b1, 25'h0002A0, 16'h0);
    repeat (16) tick();
    cl_req = 3'b001;
    tick();
    n_chk++;
    if ({sd_refresh, sd_rd} !== 2'b10) $display("FAIL ref_first: got %b want 10", {sd_refresh, sd_rd});
    else n_pass++;
    tick();
    n_chk++;
    if (sd_refresh !== 1'b0) $display("FAIL ref_width: got %b want 0", sd_refresh);
    else n_pass++;
    n = 1;
    while (!sd_rd && n < 50) begin
      tick();
      n++;
    end
    n_chk++;
    if (n !== 8) $display("FAIL ref_to_rd: got %0d want 8", n);
    else n_pass++;
    n_chk++;
    if (sd_addr !== 25'h0002A0) $display("FAIL ref_grant_addr: got %h want 0002a0", sd_addr);
    else n_pass++;
    wait_ack(n, a);
    cl_req = '0;
    tick();
  endtask

  task automatic test_ctrl_init();
    int low;
    int acks;
    reset_dut();
    hold_off = 1'b1;
    rd_data  = 16'hC0DE;
    set_client(0, 1'b0, 1'b1, 25'h000333, 16'h0);
    cl_req = 3'b001;
    tick();
    low = 0;
    repeat (40) begin
      tick();
      if (!sd_rd) low++;
    end
    n_chk++;
    if (low !== 0) $display("FAIL init_rd_held: got %0d low cycles want 0", low);
    else n_pass++;
    hold_off = 1'b0;
    acks = 0;
    repeat (40) begin
      tick();
      if (cl_ack[0]) begin
        acks++;
        cl_req = '0;
      end
    end
    n_chk++;
    if (acks !== 1) $display("FAIL init_ack_count: got %0d want 1", acks);
    else n_pass++;
    n_chk++;
    if (cl_dout !== 16'hC0DE) $display("FAIL init_dout: got %h want c0de", cl_dout);
    else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    int n;
    int acks;
    logic [2:0] a;
    reset_dut();
    rd_data = 16'h5A5A;
    set_client(0, 1'b0, 1'b1, 25'h000040, 16'h0);
    cl_req = 3'b001;
    wait_ack(n, a);
    cl_req = '0;
    tick();
    set_client(1, 1'b0, 1'b1, 25'h000080, 16'h0);
    cl_req = 3'b010;
    repeat (3) tick();
    n_chk++;
    if ({sd_busy, sd_rd} !== 2'b10) $display("FAIL mid_wait_state: got %b want 10", {sd_busy, sd_rd});
    else n_pass++;
    reset = 1'b1;
    cl_req = '0;
    #1;
    n_chk++;
    if ({cl_dout, sd_addr, sd_din, sd_rd, sd_wr, sd_word, sd_refresh, cl_ack} !== 64'b0)
      $display("FAIL mid_reset_outs: got %h/%h/%b want 0", cl_dout, sd_addr, {sd_rd, sd_wr, sd_refresh, cl_ack});
    else n_pass++;
    acks = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (cl_ack != 3'b000) acks++;
    end
    reset = 1'b0;
    repeat (10) begin
      tick();
      if (cl_ack != 3'b000) acks++;
    end
    n_chk++;
    if (acks !== 0) $display("FAIL mid_reset_no_ack: got %0d acks want 0", acks);
    else n_pass++;
    rd_data = 16'h1234;
    set_client(2, 1'b0, 1'b1, 25'h0000C0, 16'h0);
    cl_req = 3'b100;
    wait_ack(n, a);
    n_chk++;
    if (a !== 3'b100) $display("FAIL post_reset_ack: got %b want 100", a);
    else n_pass++;
    n_chk++;
    if (cl_dout !== 16'h1234) $display("FAIL post_reset_dout: got %h want 1234", cl_dout);
    else n_pass++;
    cl_req = '0;
    tick();
  endtask

  task automatic test_no_overlap();
    n_chk++;
    if (n_overlap !== 0) $display("FAIL strobe_overlap: got %0d cycles want 0", n_overlap);
    else n_pass++;
  endtask

  initial begin
    reset    = 1'b1;
    hold_off = 1'b0;
    rd_data  = '0;
    cl_req   = '0;
    cl_we    = '0;
    cl_word  = '0;
    cl_addr  = '0;
    cl_din   = '0;
    test_reset();
    test_single_read();
    test_byte_write();
    test_round_robin();
    test_refresh_priority();
    test_ctrl_init();
    test_reset_mid_wait();
    test_no_overlap();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single-port SDRAM controller (edge-triggered rd/wr, busy, 25-bit byte address, word/byte access) between NREQ client requesters, e.g. CPU ROM, WRAM and ARAM.
- Converts per-client level request/ack handshakes into controller rd/wr edges.
- Grants round-robin and inserts periodic refresh cycles when the refresh interval expires.
- Sits between the core memory clients and the sdram controller, in the same clk domain.

Parameters:
- NREQ, 3, number of client ports (2..4).
- REFRESH_INTERVAL, 512, clk cycles between forced refresh requests.
- REF_HOLD, 6, cycles to wait after a refresh pulse before the next grant (controller cycle length + 1).

Ports:
- clk  in  1  system clock, same as the sdram controller.
- reset  in  1  asynchronous, active-high reset.
- cl_req  in  NREQ  per-client request level; held with its fields until cl_ack.
- cl_we  in  NREQ  1 = write, 0 = read.
- cl_word  in  NREQ  1 = 16-bit access, 0 = byte access.
- cl_addr  in  NREQ*25  packed byte addresses; client i at [25*i +: 25].
- cl_din  in  NREQ*16  packed write data.
- cl_ack  out  NREQ  one-cycle completion pulse per client.
- cl_dout  out  16  read data, valid in the cl_ack cycle; shared by all clients.
- sd_addr  out  25  to controller addr.
- sd_rd  out  1  to controller rd.
- sd_wr  out  1  to controller wr.
- sd_word  out  1  to controller word.
- sd_din  out  16  to controller din.
- sd_dout  in  16  from controller dout.
- sd_busy  in  1  from controller busy.
- sd_refresh  out  1  to controller refresh.

Behaviour:
- Reset values: state=IDLE; cl_ack=0; cl_dout=0; sd_rd=0; sd_wr=0; sd_refresh=0; sd_addr=0; sd_word=0; sd_din=0; rr_ptr=0; ref_cnt=0; ref_pending=0.
- Refresh counter: ref_cnt increments every cycle. At REFRESH_INTERVAL-1 it wraps to 0 and sets ref_pending. ref_pending clears when the REF state is entered. An expiry while ref_pending is already set does not queue a second refresh.
- IDLE:
  - If ref_pending -> REF. Refresh beats client requests.
  - Else if any cl_req -> grant the first requester at or after rr_ptr, searching modulo NREQ.
  - On grant: latch sd_addr, sd_word, sd_din and grant index g from the client fields; raise sd_wr if cl_we[g], else sd_rd; -> ISSUE.
- ISSUE:
  - Hold sd_rd/sd_wr high until sd_busy=1. The controller may be mid-init or mid-refresh; holding the level guarantees it detects the edge once idle.
  - On sd_busy=1: drop sd_rd/sd_wr -> WAIT.
- WAIT: on sd_busy=0, capture cl_dout <= sd_dout (capture writes too; value is don't-care), pulse cl_ack[g] for 1 cycle, set rr_ptr = (g+1) mod NREQ -> DONE.
- DONE: one bubble cycle so the client can drop or re-present cl_req; then -> IDLE. A client holding cl_req high after its ack is treated as a new request.
- REF: assert sd_refresh for exactly 1 cycle, then wait REF_HOLD cycles with all sd_* strobes low -> IDLE.
- Never assert sd_rd/sd_wr and sd_refresh in the same cycle.
- Latency (controller with 5-cycle access, starting idle): grant to cl_ack = 8 cycles. Minimum request-to-request spacing = 9 cycles.
- Client fields are sampled only at grant; later changes are ignored until the next grant.
- cl_req dropped by a client before its ack: the in-flight access still completes and cl_ack still pulses. The client must ignore it.
- Asynchronous reset mid-access: all outputs return to reset values immediately and no ack is issued. The controller finishes its cycle independently.
- sd_busy seen high in IDLE (a stray condition): do not grant until it is low.

Decomposition:
- Shared package sdram_pkg holds:
  - typedef arb_state_t {IDLE, ISSUE, WAIT, DONE, REF};
  - constants ADDR_W=25 and DATA_W=16.
- Sub-module rr_pick: combinational round-robin selector (req vector, rr_ptr -> grant index, any_req). It is reused by later arbiters.

Test Plan:
- Single read: client 1 requests addr=0x000124, word=1; controller model returns 0xBEEF -> sd_rd rises the cycle after the request; cl_ack[1] pulses; cl_dout=0xBEEF; sd_rd is low from the cycle after sd_busy=1.
- Round-robin: all three clients request continuously -> grants in order 0,1,2,0,1,2; no client is starved; each cl_ack is exactly 1 cycle.
- Byte write: client 2, addr=0x000011, word=0, din=0x00AB -> sd_wr=1, sd_word=0, sd_din=0x00AB, sd_addr=0x000011; cl_ack[2] pulses after sd_busy falls.
- Refresh priority: with REFRESH_INTERVAL=16, ref_pending and cl_req[0] present in IDLE together -> sd_refresh pulses 1 cycle first; the grant to client 0 is issued exactly REF_HOLD+1 cycles later; rd/wr are never asserted together with refresh.
- Controller in init: hold sd_busy=0 for 40 cycles after sd_rd rises -> sd_rd stays high throughout; the access completes once busy toggles; exactly one ack.
- Reset mid-WAIT: assert reset while sd_busy=1 -> outputs go to reset values the same cycle; no cl_ack; after release, a new request completes normally.
